backward_reg_slice: RTL and testbench
=====================================

Name: backward_reg_slice

Overview:
- Stream register slice that breaks the ready path (m_out_tready to s_in_tready) with a registered ready and a one-entry skid buffer.
- Counterpart to the forward (data/valid) slice. Chaining both gives full timing isolation between data_route stages.
- Data passes combinationally when the slice is empty and from the skid register when downstream stalls.
- Carries tlast and exposes stall statistics for debug.

Parameters:
- DWIDTH, 32, payload width in bits.
- CWIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- s_in_tdata  input  DWIDTH  upstream payload.
- s_in_tlast  input  1  upstream end-of-packet marker.
- s_in_tvalid  input  1  upstream valid.
- s_in_tready  output  1  registered ready to upstream.
- m_out_tdata  output  DWIDTH  downstream payload.
- m_out_tlast  output  1  downstream end-of-packet marker.
- m_out_tvalid  output  1  downstream valid.
- m_out_tready  input  1  downstream ready.
- skid_full  output  1  high while the skid register holds a beat.
- stall_cnt  output  CWIDTH  saturating count of cycles spent in SKID.
- stall_clr  input  1  synchronous clear of stall_cnt.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = PASS; s_in_tready = 0; skid data/tlast = 0; stall_cnt = 0.
  - Therefore m_out_tvalid = 0 and skid_full = 0.
- First rising edge with rst_n high: s_in_tready <= 1.
- Handshake: a beat transfers on an interface when tvalid and tready are both 1 at a rising edge. m_out_tvalid never depends combinationally on m_out_tready.
- State PASS (skid empty):
  - m_out_tdata/tlast = s_in_tdata/tlast (combinational, zero latency).
  - m_out_tvalid = s_in_tvalid & s_in_tready.
  - If s_in_tvalid & s_in_tready & ~m_out_tready at an edge: capture s_in_tdata/tlast into the skid register, s_in_tready <= 0, go to SKID.
  - Otherwise s_in_tready <= 1 and stay in PASS.
- State SKID (skid holds one beat):
  - m_out_tdata/tlast = skid register; m_out_tvalid = 1; s_in_tready = 0, so no upstream beat is accepted.
  - If m_out_tready at an edge: skid beat is consumed, s_in_tready <= 1, go to PASS.
  - Else hold; the skid contents must not change.
- Ready latency: upstream sees a downstream stall one cycle late. At most one beat is in flight during that cycle, and the skid absorbs it. No beat is dropped or duplicated; order is preserved.
- skid_full = (state == SKID).
- stall_cnt:
  - Increments by 1 on every edge where state == SKID.
  - Saturates at 2^CWIDTH-1 and never wraps.
  - stall_clr at an edge sets it to 0; clear has priority over increment.
- Data in PASS with m_out_tvalid = 0 is don't-care. Verification must compare payload only on transfers.
- Reset mid-operation: any skid beat is discarded; outputs return to reset values immediately (asynchronous).
- Throughput: sustains one beat per cycle while m_out_tready stays high.

Test Plan:
- Reset release, s_in_tvalid = 1 held, m_out_tready = 1, data 0..15 -> s_in_tready rises 1 cycle after release; 16 beats out in order, one per cycle; skid_full stays 0.
- Single stall: m_out_tready drops for 1 cycle while data 0x10,0x11,0x12 stream -> 0x11 captured in skid, s_in_tready low 1 cycle, output order 0x10,0x11,0x12, stall_cnt = 1.
- Long stall: m_out_tready low 5 cycles with a beat pending -> m_out_tvalid held 1 with stable m_out_tdata/tlast, skid_full = 1 for 5 cycles, stall_cnt = 5, no upstream beat accepted.
- Random tvalid/tready (50% each, 10k beats, tlast every 8th beat) -> scoreboard matches data and tlast exactly; m_out_tvalid never drops without a transfer.
- CWIDTH = 4, hold stall 20 cycles, then pulse stall_clr -> stall_cnt saturates at 15, then reads 0 after the clear edge.
- Assert rst_n low while skid_full = 1 -> m_out_tvalid, s_in_tready and skid_full go 0 without a clock edge; after release, the first beat out is new upstream data.

Source files
------------

// File: rtl/backward_reg_slice.sv
// -----------------------------------------------------------------------------
// backward_reg_slice
//
// Stream register slice that cuts the combinational ready path between
// m_out_tready and s_in_tready. Upstream ready comes straight from a flop. A
// one-entry skid register catches the single beat that can be in flight during
// the cycle in which upstream has not yet seen a downstream stall.
//
// When the skid is empty (PASS), data, tlast and valid flow through with zero
// latency. While the skid holds a beat (SKID), the output is driven from the
// skid register and upstream is held off.
//
// Ports:
//   clk, rst_n     clock; asynchronous active-low reset
//   s_in_*         upstream stream (tdata, tlast, tvalid in; tready out)
//   m_out_*        downstream stream (tdata, tlast, tvalid out; tready in)
//   skid_full      high while the skid register holds a beat
//   stall_cnt      saturating count of clock edges spent in SKID
//   stall_clr      synchronous clear of stall_cnt (wins over increment)
// -----------------------------------------------------------------------------
module backward_reg_slice #(
   parameter int DWIDTH = 32,
   parameter int CWIDTH = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DWIDTH-1:0] s_in_tdata,
   input  logic              s_in_tlast,
   input  logic              s_in_tvalid,
   output logic              s_in_tready,
   output logic [DWIDTH-1:0] m_out_tdata,
   output logic              m_out_tlast,
   output logic              m_out_tvalid,
   input  logic              m_out_tready,
   output logic              skid_full,
   output logic [CWIDTH-1:0] stall_cnt,
   input  logic              stall_clr
);

   typedef enum logic {
      PASS = 1'b0,
      SKID = 1'b1
   } state_e;

   localparam logic [CWIDTH-1:0] CNT_MAX = {CWIDTH{1'b1}};
   localparam logic [CWIDTH-1:0] CNT_ONE = {{(CWIDTH-1){1'b0}}, 1'b1};

   state_e            state_q, state_d;
   logic              rdy_q, rdy_d;
   logic [DWIDTH-1:0] skid_data_q, skid_data_d;
   logic              skid_last_q, skid_last_d;
   logic [CWIDTH-1:0] stall_cnt_q, stall_cnt_d;

   // An upstream beat is accepted only when the registered ready is high. In
   // SKID the registered ready is always low.
   logic in_xfer;
   assign in_xfer = s_in_tvalid & rdy_q;

   always_comb begin
      // NOTE: every signal gets its hold value first so no path through this
      // block leaves a signal unassigned, which would infer a latch.
      state_d     = state_q;
      rdy_d       = rdy_q;
      skid_data_d = skid_data_q;
      skid_last_d = skid_last_q;
      stall_cnt_d = stall_cnt_q;

      unique case (state_q)
         PASS: begin
            if (in_xfer && !m_out_tready) begin
               // Downstream refused the beat that upstream just handed over.
               // Park it, and drop ready so that nothing else arrives.
               skid_data_d = s_in_tdata;
               skid_last_d = s_in_tlast;
               rdy_d       = 1'b0;
               state_d     = SKID;
            end else begin
               rdy_d = 1'b1;
            end
         end
         SKID: begin
            if (m_out_tready) begin
               rdy_d   = 1'b1;
               state_d = PASS;
            end
         end
         default: begin
            state_d = PASS;
         end
      endcase

      if (stall_clr) begin
         stall_cnt_d = '0;
      end else if (state_q == SKID && stall_cnt_q != CNT_MAX) begin
         stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
   end

   // NOTE: sequential state is written only with non-blocking assignments, so
   // every flop samples its _d value from before the clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= PASS;
         rdy_q       <= 1'b0;
         // NOTE: the skid payload register is reset as well. It is a single
         // register, not a memory array, and a reset that discards the held
         // beat leaves nothing stale on m_out_tdata.
         skid_data_q <= '0;
         skid_last_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= rdy_d;
         skid_data_q <= skid_data_d;
         skid_last_q <= skid_last_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Output valid depends only on state, upstream valid and the ready flop.
   // It never depends on m_out_tready.
   assign skid_full    = (state_q == SKID);
   assign s_in_tready  = rdy_q;
   assign m_out_tvalid = skid_full | in_xfer;
   assign m_out_tdata  = skid_full ? skid_data_q : s_in_tdata;
   assign m_out_tlast  = skid_full ? skid_last_q : s_in_tlast;
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_backward_reg_slice.sv
// -----------------------------------------------------------------------------
// tb_backward_reg_slice
//
// Directed and random stimulus for backward_reg_slice (DWIDTH=32, CWIDTH=4).
// Inputs change on the falling edge and outputs are sampled 1 ns later. A
// queue of accepted upstream beats is checked against every downstream
// transfer.
// -----------------------------------------------------------------------------
module tb_backward_reg_slice;

   localparam int DW = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [DW-1:0] s_in_tdata;
   logic          s_in_tlast;
   logic          s_in_tvalid;
   logic          s_in_tready;
   logic [DW-1:0] m_out_tdata;
   logic          m_out_tlast;
   logic          m_out_tvalid;
   logic          m_out_tready;
   logic          skid_full;
   logic [CW-1:0] stall_cnt;
   logic          stall_clr;

   backward_reg_slice #(.DWIDTH(DW), .CWIDTH(CW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_in_tdata   (s_in_tdata),
      .s_in_tlast   (s_in_tlast),
      .s_in_tvalid  (s_in_tvalid),
      .s_in_tready  (s_in_tready),
      .m_out_tdata  (m_out_tdata),
      .m_out_tlast  (m_out_tlast),
      .m_out_tvalid (m_out_tvalid),
      .m_out_tready (m_out_tready),
      .skid_full    (skid_full),
      .stall_cnt    (stall_cnt),
      .stall_clr    (stall_clr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard entries are {tlast, tdata}.
   logic [DW:0]   sb[$];
   int            n_out = 0;
   logic          prev_pending = 1'b0;
   logic [DW:0]   prev_beat = '0;
   logic          acc;
   logic          obs_s_rdy;
   logic          obs_skid;
   logic [DW-1:0] obs_data;
   logic          obs_last;

   // One clock cycle: entered on a falling edge, drives the inputs, samples the
   // outputs, updates the scoreboard and returns on the next falling edge.
   task automatic step(input logic vld, input logic [DW-1:0] d, input logic l,
                       input logic ordy);
      logic [DW:0] exp_beat;
      s_in_tvalid  = vld;
      s_in_tdata   = d;
      s_in_tlast   = l;
      m_out_tready = ordy;
      #1;
      acc       = vld & s_in_tready;
      obs_s_rdy = s_in_tready;
      obs_skid  = skid_full;
      obs_data  = m_out_tdata;
      obs_last  = m_out_tlast;
      if (prev_pending) begin
         check("vld_hold", 64'(m_out_tvalid), 64'(1'b1));
         check("beat_hold", 64'({m_out_tlast, m_out_tdata}), 64'(prev_beat));
      end
      if (acc) sb.push_back({l, d});
      if (m_out_tvalid && ordy) begin
         if (sb.size() == 0) begin
            check("sb_underflow", 64'(sb.size()), 64'(1));
         end else begin
            exp_beat = sb.pop_front();
            check("out_beat", 64'({m_out_tlast, m_out_tdata}), 64'(exp_beat));
         end
         n_out++;
      end
      prev_pending = m_out_tvalid & ~ordy;
      prev_beat    = {m_out_tlast, m_out_tdata};
      @(negedge clk);
   endtask

   initial begin
      int steps;
      int d;
      int n0;
      logic saw_skid;

      rst_n        = 1'b0;
      s_in_tvalid  = 1'b1;
      s_in_tdata   = '0;
      s_in_tlast   = 1'b0;
      m_out_tready = 1'b1;
      stall_clr    = 1'b0;

      // ---------------- Reset state ----------------
      repeat (2) @(negedge clk);
      #1;
      check("rst_s_rdy", 64'(s_in_tready), 64'(1'b0));
      check("rst_m_vld", 64'(m_out_tvalid), 64'(1'b0));
      check("rst_skid", 64'(skid_full), 64'(1'b0));
      check("rst_cnt", 64'(stall_cnt), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // ---------------- Stream 0..15 at full rate ----------------
      steps    = 0;
      d        = 0;
      saw_skid = 1'b0;
      while (d < 16 && steps < 40) begin
         step(1'b1, DW'(d), 1'b0, 1'b1);
         steps++;
         if (steps == 1) check("rel_rdy_c0", 64'(obs_s_rdy), 64'(1'b0));
         if (steps == 2) check("rel_rdy_c1", 64'(obs_s_rdy), 64'(1'b1));
         if (obs_skid) saw_skid = 1'b1;
         if (acc) d++;
      end
      check("stream_cycles", 64'(steps), 64'(17));
      check("stream_outs", 64'(n_out), 64'(16));
      check("stream_noskid", 64'(saw_skid), 64'(1'b0));

      // ---------------- Single-cycle stall ----------------
      step(1'b1, 32'h10, 1'b0, 1'b1);
      check("s1_acc10", 64'(acc), 64'(1'b1));
      step(1'b1, 32'h11, 1'b0, 1'b0);
      check("s1_acc11", 64'(acc), 64'(1'b1));
      check("s1_skid_b", 64'(obs_skid), 64'(1'b0));
      step(1'b1, 32'h12, 1'b0, 1'b1);
      check("s1_rdy_low", 64'(obs_s_rdy), 64'(1'b0));
      check("s1_skid_c", 64'(obs_skid), 64'(1'b1));
      check("s1_out11", 64'(obs_data), 64'(32'h11));
      check("s1_noacc", 64'(acc), 64'(1'b0));
      step(1'b1, 32'h12, 1'b0, 1'b1);
      check("s1_acc12", 64'(acc), 64'(1'b1));
      check("s1_out12", 64'(obs_data), 64'(32'h12));
      step(1'b0, '0, 1'b0, 1'b1);
      check("s1_cnt", 64'(stall_cnt), 64'(1));
      check("s1_sb_empty", 64'(sb.size()), 64'(0));

      // ---------------- Five-cycle stall ----------------
      stall_clr = 1'b1;
      step(1'b0, '0, 1'b0, 1'b1);
      stall_clr = 1'b0;
      check("s5_clr", 64'(stall_cnt), 64'(0));
      step(1'b1, 32'h20, 1'b1, 1'b0);
      check("s5_acc20", 64'(acc), 64'(1'b1));
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'h21, 1'b0, 1'b0);
         check("s5_skid", 64'(obs_skid), 64'(1'b1));
         check("s5_rdy", 64'(obs_s_rdy), 64'(1'b0));
         check("s5_noacc", 64'(acc), 64'(1'b0));
         check("s5_beat", 64'({obs_last, obs_data}), 64'({1'b1, 32'h20}));
      end
      step(1'b1, 32'h21, 1'b0, 1'b1);
      check("s5_skid_last", 64'(obs_skid), 64'(1'b1));
      check("s5_noacc_last", 64'(acc), 64'(1'b0));
      step(1'b1, 32'h21, 1'b0, 1'b1);
      check("s5_acc21", 64'(acc), 64'(1'b1));
      check("s5_skid_off", 64'(obs_skid), 64'(1'b0));
      step(1'b0, '0, 1'b0, 1'b1);
      check("s5_cnt", 64'(stall_cnt), 64'(5));

      // ---------------- Counter saturation and clear priority ----------------
      stall_clr = 1'b1;
      step(1'b0, '0, 1'b0, 1'b1);
      stall_clr = 1'b0;
      step(1'b1, 32'h30, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step(1'b1, 32'h31, 1'b0, 1'b0);
      check("sat_cnt", 64'(stall_cnt), 64'(15));
      check("sat_noacc", 64'(acc), 64'(1'b0));
      stall_clr = 1'b1;
      step(1'b1, 32'h31, 1'b0, 1'b0);
      stall_clr = 1'b0;
      check("sat_clr", 64'(stall_cnt), 64'(0));
      step(1'b1, 32'h31, 1'b0, 1'b1);
      step(1'b1, 32'h31, 1'b0, 1'b1);
      check("sat_acc31", 64'(acc), 64'(1'b1));
      step(1'b0, '0, 1'b0, 1'b1);
      check("sat_sb_empty", 64'(sb.size()), 64'(0));

      // ---------------- Asynchronous reset while the skid is full ----------------
      step(1'b1, 32'h40, 1'b0, 1'b0);
      check("ar_skid_pre", 64'(skid_full), 64'(1'b1));
      #2 rst_n = 1'b0;
      #1;
      check("ar_m_vld", 64'(m_out_tvalid), 64'(1'b0));
      check("ar_s_rdy", 64'(s_in_tready), 64'(1'b0));
      check("ar_skid", 64'(skid_full), 64'(1'b0));
      check("ar_cnt", 64'(stall_cnt), 64'(0));
      sb.delete();
      prev_pending = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n0    = n_out;
      d     = 0;
      steps = 0;
      while (d < 3 && steps < 20) begin
         step(1'b1, DW'(32'h50 + d), 1'b0, 1'b1);
         if (n_out == n0 + 1 && d == 0 && acc)
            check("ar_first", 64'(obs_data), 64'(32'h50));
         if (acc) d++;
         steps++;
      end
      check("ar_outs", 64'(n_out - n0), 64'(3));

      // ---------------- Random valid/ready, 10k beats ----------------
      begin
         int            idx;
         int            cyc;
         int            k;
         logic          cur_v;
         logic [DW-1:0] cur_d;
         idx   = 0;
         cyc   = 0;
         cur_v = 1'b0;
         cur_d = '0;
         n0    = n_out;
         while (idx < 10000 && cyc < 60000) begin
            if (!cur_v) begin
               cur_v = 1'($urandom_range(0, 1));
               cur_d = $urandom;
            end
            step(cur_v, cur_d, (idx % 8) == 7, 1'($urandom_range(0, 1)));
            if (acc) begin
               idx++;
               cur_v = 1'b0;
            end
            cyc++;
         end
         check("rnd_accepted", 64'(idx), 64'(10000));
         k = 0;
         while (sb.size() > 0 && k < 10) begin
            step(1'b0, '0, 1'b0, 1'b1);
            k++;
         end
         check("rnd_outs", 64'(n_out - n0), 64'(10000));
         check("rnd_sb_empty", 64'(sb.size()), 64'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
